// File: rtl/systolic_pkg.sv
// systolic_pkg: types and constants shared by the systolic array and its result collector
package systolic_pkg;
   localparam int DEFAULT_DATA_WIDTH = 8;
   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} collector_state_t;
endpackage

// File: rtl/row_fifo.sv
// row_fifo: synchronous FIFO with registered head data and an explicit occupancy counter
module row_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, head_nxt;
   logic do_push, do_pop;
   assign full  = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   always_comb begin
      do_pop   = pop && !empty && !flush;
      do_push  = push && !flush && (!full || do_pop);
      head_nxt = rd_ptr + AW'(do_pop);
   end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wr_data;
   // The head register takes the incoming row directly when it becomes the new head.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr  <= head_nxt;
         count   <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
         rd_data <= (do_push && head_nxt == wr_ptr) ? wr_data : mem[head_nxt];
      end
endmodule

// File: rtl/systolic_result_collector.sv
// systolic_result_collector: deskews column results, buffers rows and hands them downstream
module systolic_result_collector
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int NUM_ROWS   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] y0,
   input  logic [DATA_WIDTH-1:0] y1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_y0,
   output logic [DATA_WIDTH-1:0] out_y1,
   output logic                  out_last,
   output logic                  done,
   output logic                  overflow
);
   localparam int FW = 2*DATA_WIDTH + 1;
   collector_state_t state;
   logic [DATA_WIDTH-1:0] y0_d;
   logic valid_d, last, pop, accept, full, empty;
   logic [7:0] row_cnt;
   logic [FW-1:0] rd_data;
   logic [$clog2(FIFO_DEPTH):0] count;
   assign last   = row_cnt == 8'(NUM_ROWS-1);
   assign pop    = out_valid && out_ready;
   // The array cannot stall, so a row either fits this cycle or is lost.
   assign accept = valid_d && state != DRAIN && (!full || pop);
   assign out_valid = !empty;
   assign out_y1    = rd_data[FW-1 -: DATA_WIDTH];
   assign out_y0    = rd_data[DATA_WIDTH:1];
   assign out_last  = rd_data[0];
   row_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (start),
      .push    (accept),
      .pop     (pop),
      .wr_data ({y1, y0_d, last}),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state    <= IDLE;
         y0_d     <= '0;
         valid_d  <= 1'b0;
         row_cnt  <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else if (start) begin
         state    <= IDLE;
         y0_d     <= '0;
         valid_d  <= 1'b0;
         row_cnt  <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         valid_d <= in_valid;
         y0_d    <= y0;
         done    <= 1'b0;
         if (valid_d && !accept) overflow <= 1'b1;
         if (valid_d) row_cnt <= last ? '0 : row_cnt + 8'd1;
         case (state)
            IDLE:    if (valid_d) state <= last ? DRAIN : COLLECT;
            COLLECT: if (valid_d && last) state <= DRAIN;
            DRAIN:   if (count == '0) begin
               state   <= IDLE;
               done    <= 1'b1;
               row_cnt <= '0;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_systolic_result_collector.sv
// tb_systolic_result_collector: directed checks on a 2-row and a 6-row collector
module tb_systolic_result_collector;
   logic clk = 1'b0, reset, start, in_valid, out_ready;
   logic [7:0] y0, y1;
   logic a_valid, a_last, a_done, a_ovf, b_valid, b_last, b_done, b_ovf;
   logic [7:0] a_y0, a_y1, b_y0, b_y1;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   systolic_result_collector #(.DATA_WIDTH(8), .NUM_ROWS(2), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .y0(y0), .y1(y1),
      .out_valid(a_valid), .out_ready(out_ready), .out_y0(a_y0), .out_y1(a_y1),
      .out_last(a_last), .done(a_done), .overflow(a_ovf));

   systolic_result_collector #(.DATA_WIDTH(8), .NUM_ROWS(6), .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .y0(y0), .y1(y1),
      .out_valid(b_valid), .out_ready(out_ready), .out_y0(b_y0), .out_y1(b_y1),
      .out_last(b_last), .done(b_done), .overflow(b_ovf));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic st, input logic iv, input logic [7:0] a0, input logic [7:0] a1,
                      input logic rdy);
      start = st; in_valid = iv; y0 = a0; y1 = a1; out_ready = rdy;
      @(posedge clk); #1;
   endtask

   task automatic run_basic();
      cyc(0, 1, 3, 0, 1);
      chk("basic_v_early", a_valid, 0);
      chk("basic_no_done", a_done, 0);
      cyc(0, 1, 7, 5, 1);
      chk("basic_r0_v", a_valid, 1);
      chk("basic_r0_y0", a_y0, 3);
      chk("basic_r0_y1", a_y1, 5);
      chk("basic_r0_last", a_last, 0);
      cyc(0, 0, 0, 9, 1);
      chk("basic_r1_v", a_valid, 1);
      chk("basic_r1_y0", a_y0, 7);
      chk("basic_r1_y1", a_y1, 9);
      chk("basic_r1_last", a_last, 1);
      cyc(0, 0, 0, 0, 1);
      chk("basic_empty", a_valid, 0);
      chk("basic_done_early", a_done, 0);
      cyc(0, 0, 0, 0, 1);
      chk("basic_done", a_done, 1);
      cyc(0, 0, 0, 0, 1);
      chk("basic_done_once", a_done, 0);
      chk("basic_ovf", a_ovf, 0);
   endtask

   // Rows 0,1 fill the 2-row matrix; rows 2..4 arrive during drain and are dropped.
   task automatic setup_ov();
      cyc(1, 0, 0, 0, 0);
      for (int c = 0; c < 5; c++) cyc(0, 1, 8'(20 + c), c > 0 ? 8'(30 + c - 1) : 8'd0, 0);
      cyc(0, 0, 0, 34, 0);
      chk("setup_ovf", a_ovf, 1);
      chk("setup_v", a_valid, 1);
      chk("setup_y0", a_y0, 20);
      chk("setup_y1", a_y1, 30);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; y0 = '0; y1 = '0; out_ready = 1'b0;
      #3;
      chk("rst_v", a_valid, 0);
      chk("rst_y0", a_y0, 0);
      chk("rst_y1", a_y1, 0);
      chk("rst_last", a_last, 0);
      chk("rst_done", a_done, 0);
      chk("rst_ovf", a_ovf, 0);
      #10 reset = 1'b1;

      cyc(1, 0, 0, 0, 1);
      run_basic();

      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 3, 0, 0);
      chk("bp_v_early", a_valid, 0);
      cyc(0, 1, 7, 5, 0);
      chk("bp_v", a_valid, 1);
      chk("bp_y0", a_y0, 3);
      chk("bp_y1", a_y1, 5);
      for (int c = 2; c < 6; c++) begin
         cyc(0, 0, 0, c == 2 ? 8'd9 : 8'd0, 0);
         chk("bp_hold_v", a_valid, 1);
         chk("bp_hold_y0", a_y0, 3);
         chk("bp_hold_y1", a_y1, 5);
      end
      cyc(0, 0, 0, 0, 1);
      chk("bp_r1_y0", a_y0, 7);
      chk("bp_r1_y1", a_y1, 9);
      chk("bp_r1_last", a_last, 1);
      cyc(0, 0, 0, 0, 1);
      chk("bp_empty", a_valid, 0);
      chk("bp_done_early", a_done, 0);
      cyc(0, 0, 0, 0, 1);
      chk("bp_done", a_done, 1);
      cyc(0, 0, 0, 0, 1);
      chk("bp_done_once", a_done, 0);

      cyc(1, 0, 0, 0, 0);
      for (int c = 0; c < 6; c++) begin
         cyc(0, 1, 8'(10 * (c + 1)), c > 0 ? 8'(10 * c + 1) : 8'd0, 0);
         chk("ov_flag", b_ovf, c >= 5);
      end
      cyc(0, 0, 0, 61, 0);
      chk("ov_flag_end", b_ovf, 1);
      chk("ov_v", b_valid, 1);
      chk("ov_r0_y0", b_y0, 10);
      chk("ov_r0_y1", b_y1, 11);
      for (int k = 1; k < 4; k++) begin
         cyc(0, 0, 0, 0, 1);
         chk("ov_rk_v", b_valid, 1);
         chk("ov_rk_y0", b_y0, 10 * (k + 1));
         chk("ov_rk_y1", b_y1, 10 * (k + 1) + 1);
         chk("ov_rk_last", b_last, 0);
      end
      cyc(0, 0, 0, 0, 1);
      chk("ov_four_rows", b_valid, 0);
      cyc(0, 0, 0, 0, 1);
      chk("ov_done", b_done, 1);

      cyc(1, 0, 0, 0, 0);
      for (int c = 0; c < 5; c++) cyc(0, 1, 8'(100 + c), c > 0 ? 8'(200 + c - 1) : 8'd0, 0);
      chk("fs_head", b_y0, 100);
      cyc(0, 1, 105, 204, 1);
      chk("fs_ovf", b_ovf, 0);
      chk("fs_r1_y0", b_y0, 101);
      cyc(0, 0, 0, 205, 1);
      chk("fs_r2_y0", b_y0, 102);
      chk("fs_r2_y1", b_y1, 202);
      cyc(0, 0, 0, 0, 1);
      chk("fs_r3_y0", b_y0, 103);
      cyc(0, 0, 0, 0, 1);
      chk("fs_r4_y0", b_y0, 104);
      chk("fs_r4_y1", b_y1, 204);
      cyc(0, 0, 0, 0, 1);
      chk("fs_r5_y0", b_y0, 105);
      chk("fs_r5_y1", b_y1, 205);
      chk("fs_r5_last", b_last, 1);
      cyc(0, 0, 0, 0, 1);
      chk("fs_empty", b_valid, 0);
      cyc(0, 0, 0, 0, 1);
      chk("fs_done", b_done, 1);
      chk("fs_ovf_end", b_ovf, 0);

      setup_ov();
      #2 reset = 1'b0;
      #1;
      chk("arst_v", a_valid, 0);
      chk("arst_done", a_done, 0);
      chk("arst_ovf", a_ovf, 0);
      chk("arst_y0", a_y0, 0);
      #3 reset = 1'b1;
      run_basic();

      setup_ov();
      cyc(1, 1, 99, 0, 1);
      chk("st_v", a_valid, 0);
      chk("st_ovf", a_ovf, 0);
      chk("st_done", a_done, 0);
      run_basic();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
